// File: rtl/pbit_pkg.sv
// Shared types and default sizing for the p-bit sample decoder.
package pbit_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 16;
  localparam int SETTLE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_DECIDE
  } state_e;

endpackage

// File: rtl/pbit_sample_decoder_if.sv
// Request/sample/result bundle between a p-bit adder harness (master) and the decoder (slave).
interface pbit_sample_decoder_if #(
  parameter int WIDTH = pbit_pkg::DEF_WIDTH,
  parameter int CNT_W = pbit_pkg::DEF_CNT_W
);

  logic                         start;
  logic [CNT_W-1:0]             steps;
  logic [pbit_pkg::SETTLE_W-1:0] settle;
  logic [WIDTH-1:0]             a_in;
  logic [WIDTH-1:0]             b_in;
  logic [WIDTH-1:0]             sum_in;
  logic                         ovf_in;

  logic                         busy;
  logic                         done;
  logic [WIDTH-1:0]             a_dec;
  logic [WIDTH-1:0]             b_dec;
  logic [WIDTH-1:0]             sum_dec;
  logic                         ovf_dec;
  logic [CNT_W-1:0]             consist_cnt;

  modport master (
    output start, steps, settle, a_in, b_in, sum_in, ovf_in,
    input  busy, done, a_dec, b_dec, sum_dec, ovf_dec, consist_cnt
  );

  modport slave (
    input  start, steps, settle, a_in, b_in, sum_in, ovf_in,
    output busy, done, a_dec, b_dec, sum_dec, ovf_dec, consist_cnt
  );

endinterface

// File: rtl/pbit_ones_counter.sv
// Saturation-free ones counter: counts cycles where en and bit_in are both high.
module pbit_ones_counter #(
  parameter int CNT_W = pbit_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: hold value assigned first so every path drives count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && bit_in) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state updates use <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pbit_sample_decoder.sv
// Majority decoder for stochastic p-bit adder words: settle, accumulate, decide.
// Define PBIT_DECODE_CONSIST_EN to build the a+b == {ovf,sum} consistency counter.
module pbit_sample_decoder
  import pbit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  reset,
  pbit_sample_decoder_if.slave bus
);

  localparam int NBITS = 3 * WIDTH + 1;

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     steps_q, steps_d;
  logic [CNT_W-1:0]     step_left_q, step_left_d;
  logic [SETTLE_W-1:0]  settle_left_q, settle_left_d;
  logic [NBITS-1:0]     dec_q, dec_d;

  logic [NBITS-1:0]     sample;
  logic [NBITS-1:0]     dec_now;
  logic [CNT_W-1:0]     ones_cnt [NBITS];
  logic [CNT_W-1:0]     steps_eff;
  logic                 accept;
  logic                 clr;
  logic                 sample_en;

  assign accept    = (state_q == ST_IDLE) && bus.start && !busy_q;
  assign sample    = {bus.ovf_in, bus.sum_in, bus.b_in, bus.a_in};
  assign steps_eff = (bus.steps == '0) ? CNT_W'(1) : bus.steps;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = (bus.settle == '0) ? ST_ACCUM : ST_SETTLE;
      ST_SETTLE: if (settle_left_q == SETTLE_W'(1)) state_d = ST_ACCUM;
      ST_ACCUM:  if (step_left_q == CNT_W'(1)) state_d = ST_DECIDE;
      ST_DECIDE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // busy stays high through the done cycle and drops on the following edge.
  always_comb begin
    busy_d        = busy_q;
    done_d        = 1'b0;
    steps_d       = steps_q;
    step_left_d   = step_left_q;
    settle_left_d = settle_left_q;
    dec_d         = dec_q;
    clr           = 1'b0;
    sample_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = accept;
        if (accept) begin
          steps_d       = steps_eff;
          step_left_d   = steps_eff;
          settle_left_d = bus.settle;
          clr           = 1'b1;
        end
      end
      ST_SETTLE: settle_left_d = settle_left_q - SETTLE_W'(1);
      ST_ACCUM: begin
        sample_en   = 1'b1;
        step_left_d = step_left_q - CNT_W'(1);
      end
      ST_DECIDE: begin
        dec_d  = dec_now;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      steps_q       <= '0;
      step_left_q   <= '0;
      settle_left_q <= '0;
      dec_q         <= '0;
    end else begin
      busy_q        <= busy_d;
      done_q        <= done_d;
      steps_q       <= steps_d;
      step_left_q   <= step_left_d;
      settle_left_q <= settle_left_d;
      dec_q         <= dec_d;
    end
  end

  // Doubling the count instead of halving steps keeps ties decoding to 0.
  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    pbit_ones_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .en     (sample_en),
      .bit_in (sample[i]),
      .count  (ones_cnt[i])
    );
    assign dec_now[i] = {ones_cnt[i], 1'b0} > {1'b0, steps_q};
  end

`ifdef PBIT_DECODE_CONSIST_EN
  logic [WIDTH:0]   add_sum;
  logic             consistent;
  logic [CNT_W-1:0] consist_now;
  logic [CNT_W-1:0] consist_q, consist_d;

  assign add_sum    = {1'b0, bus.a_in} + {1'b0, bus.b_in};
  assign consistent = (add_sum == {bus.ovf_in, bus.sum_in});

  pbit_ones_counter #(.CNT_W(CNT_W)) u_consist (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .en     (sample_en),
    .bit_in (consistent),
    .count  (consist_now)
  );

  always_comb begin
    consist_d = consist_q;
    if (state_q == ST_DECIDE) consist_d = consist_now;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      consist_q <= '0;
    end else begin
      consist_q <= consist_d;
    end
  end

  assign bus.consist_cnt = consist_q;
`else
  assign bus.consist_cnt = '0;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign {bus.ovf_dec, bus.sum_dec, bus.b_dec, bus.a_dec} = dec_q;

endmodule
